frame_dismantle: RTL and testbench

- Disassembles a decoded serial AES3/S/PDIF-style bit stream into its fields.
- Each subframe is an 8-bit preamble, then 4 aux bits, 20 audio bits, and V, U, C, P bits.
- Outputs audio words, aux nibbles and a 192-bit channel-status block for one selected channel.
- Sits between the line decoder/bit recoverer and the audio FIFO.

---
 rtl/frame_dismantle.sv | 259 +++++++++++++++++++++++++
 tb/tb_frame_dismantle.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_dismantle.sv
// rtl/frame_dismantle.sv - splits a decoded AES3/S/PDIF bit stream into aux, audio and channel-status fields
//
// Purpose:
//   Hunts for a subframe preamble, then collects 4 aux bits, 20 audio bits and
//   the V, U, C, P bits. It strobes out aux nibbles and audio words, and checks
//   even parity over aux..P. It gathers the C bits of one selected channel into
//   a 192-bit channel-status block, which is released only when the whole block
//   was received in sync.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   din           in   serial data bit
//   vin           in   din valid, one bit consumed per cycle with vin=1
//   in_channel    in   channel whose C bits are collected (0=A, 1=B)
//   frame_counter out  frame index within the block, 0..191
//   out_channel   out  channel of the subframe being output (0=A, 1=B)
//   dout/vout     out  audio sample, LSB received first / one-cycle strobe
//   dauxout/vauxout out aux nibble, LSB received first / one-cycle strobe
//   channeldout   out  channel-status block, bit i = C bit of frame i
//   channelvout   out  one-cycle strobe, channeldout valid
//   done          out  one-cycle strobe, subframe completed with good parity
//   kill          out  one-cycle strobe, parity error or illegal preamble order
module frame_dismantle #(
  parameter logic [7:0] PRE_B = 8'b11101000,
  parameter logic [7:0] PRE_M = 8'b11100010,
  parameter logic [7:0] PRE_W = 8'b11100100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         din,
  input  logic         vin,
  input  logic         in_channel,
  output logic [7:0]   frame_counter,
  output logic         out_channel,
  output logic [19:0]  dout,
  output logic         vout,
  output logic [3:0]   dauxout,
  output logic         vauxout,
  output logic [191:0] channeldout,
  output logic         channelvout,
  output logic         done,
  output logic         kill
);

  localparam logic [7:0] LAST_FRAME = 8'd191;

  typedef enum logic [1:0] {S_HUNT, S_AUX, S_AUDIO, S_VUCP} state_t;
  // Kind of the previous preamble, used to detect illegal ordering.
  typedef enum logic [1:0] {PV_NONE, PV_A, PV_W} prev_t;

  state_t         state_q, state_d;
  prev_t          prev_q, prev_d;
  logic [7:0]     sh_q, sh_d;
  logic [19:0]    sr_q, sr_d;
  logic [4:0]     cnt_q, cnt_d;
  logic           par_q, par_d;
  logic           c_pend_q, c_pend_d;
  logic           bs_q, bs_d;
  logic [7:0]     fc_q, fc_d;
  logic           och_q, och_d;
  logic [19:0]    dout_q, dout_d;
  logic           vout_q, vout_d;
  logic [3:0]     daux_q, daux_d;
  logic           vaux_q, vaux_d;
  logic [191:0]   cs_q, cs_d;
  logic [191:0]   cd_q, cd_d;
  logic           cv_q, cv_d;
  logic           cv_pend_q, cv_pend_d;
  logic           done_q, done_d;
  logic           kill_q, kill_d;

  logic [7:0]     sh_shift;
  logic [19:0]    sr_shift;
  logic           illegal;

  // Preamble bits arrive MSB first; field bits arrive LSB first, so the data
  // register shifts right and a completed field sits at its top end.
  assign sh_shift = {sh_q[6:0], din};
  assign sr_shift = {din, sr_q[19:1]};

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    sh_d      = sh_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    par_d     = par_q;
    c_pend_d  = c_pend_q;
    bs_d      = bs_q;
    fc_d      = fc_q;
    och_d     = och_q;
    dout_d    = dout_q;
    daux_d    = daux_q;
    cs_d      = cs_q;
    cd_d      = cd_q;
    vout_d    = 1'b0;
    vaux_d    = 1'b0;
    cv_d      = 1'b0;
    cv_pend_d = 1'b0;
    done_d    = 1'b0;
    kill_d    = 1'b0;
    illegal   = 1'b0;

    // Frame 191's C bit was written last cycle; publish the finished block.
    if (cv_pend_q) begin
      cd_d = cs_q;
      cv_d = 1'b1;
    end

    if (vin) begin
      case (state_q)
        S_HUNT: begin
          sh_d = sh_shift;
          if (sh_shift == PRE_B || sh_shift == PRE_M || sh_shift == PRE_W) begin
            sh_d    = 8'd0;
            state_d = S_AUX;
            cnt_d   = 5'd0;
            par_d   = 1'b0;
            if (sh_shift == PRE_B) begin
              fc_d    = 8'd0;
              och_d   = 1'b0;
              bs_d    = 1'b1;
              prev_d  = PV_A;
              illegal = (prev_q == PV_A);
            end else if (sh_shift == PRE_M) begin
              och_d   = 1'b0;
              fc_d    = (fc_q == LAST_FRAME) ? 8'd0 : fc_q + 8'd1;
              prev_d  = PV_A;
              illegal = (prev_q == PV_A) || (fc_q == LAST_FRAME);
            end else begin
              och_d   = 1'b1;
              prev_d  = PV_W;
              illegal = (prev_q == PV_W);
            end
            // Ordering errors break block sync but the subframe is still parsed.
            if (illegal) begin
              kill_d = 1'b1;
              bs_d   = 1'b0;
            end
          end
        end

        S_AUX: begin
          sr_d  = sr_shift;
          par_d = par_q ^ din;
          if (cnt_q == 5'd3) begin
            daux_d  = sr_shift[19:16];
            vaux_d  = 1'b1;
            cnt_d   = 5'd0;
            state_d = S_AUDIO;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end

        S_AUDIO: begin
          sr_d  = sr_shift;
          par_d = par_q ^ din;
          if (cnt_q == 5'd19) begin
            dout_d  = sr_shift;
            vout_d  = 1'b1;
            cnt_d   = 5'd0;
            state_d = S_VUCP;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end

        S_VUCP: begin
          par_d = par_q ^ din;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd2) begin
            c_pend_d = din;
          end
          if (cnt_q == 5'd3) begin
            state_d = S_HUNT;
            cnt_d   = 5'd0;
            // par_q ^ din is the xor of all 28 bits; zero means even parity.
            if ((par_q ^ din) == 1'b0) begin
              done_d = 1'b1;
              if (bs_q && (och_q == in_channel)) begin
                cs_d[fc_q] = c_pend_q;
                if (fc_q == LAST_FRAME) begin
                  cv_pend_d = 1'b1;
                end
              end
            end else begin
              kill_d = 1'b1;
              bs_d   = 1'b0;
            end
          end
        end

        default: begin
          state_d = S_HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_HUNT;
      prev_q    <= PV_NONE;
      sh_q      <= 8'd0;
      sr_q      <= 20'd0;
      cnt_q     <= 5'd0;
      par_q     <= 1'b0;
      c_pend_q  <= 1'b0;
      bs_q      <= 1'b0;
      fc_q      <= 8'd0;
      och_q     <= 1'b0;
      dout_q    <= 20'd0;
      vout_q    <= 1'b0;
      daux_q    <= 4'd0;
      vaux_q    <= 1'b0;
      cs_q      <= 192'd0;
      cd_q      <= 192'd0;
      cv_q      <= 1'b0;
      cv_pend_q <= 1'b0;
      done_q    <= 1'b0;
      kill_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      sh_q      <= sh_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      par_q     <= par_d;
      c_pend_q  <= c_pend_d;
      bs_q      <= bs_d;
      fc_q      <= fc_d;
      och_q     <= och_d;
      dout_q    <= dout_d;
      vout_q    <= vout_d;
      daux_q    <= daux_d;
      vaux_q    <= vaux_d;
      cs_q      <= cs_d;
      cd_q      <= cd_d;
      cv_q      <= cv_d;
      cv_pend_q <= cv_pend_d;
      done_q    <= done_d;
      kill_q    <= kill_d;
    end
  end

  assign frame_counter = fc_q;
  assign out_channel   = och_q;
  assign dout          = dout_q;
  assign vout          = vout_q;
  assign dauxout       = daux_q;
  assign vauxout       = vaux_q;
  assign channeldout   = cd_q;
  assign channelvout   = cv_q;
  assign done          = done_q;
  assign kill          = kill_q;

endmodule

// File: tb/tb_frame_dismantle.sv
// tb/tb_frame_dismantle.sv - directed self-checking bench for frame_dismantle
module tb_frame_dismantle;

  localparam logic [7:0] PRE_B = 8'b11101000;
  localparam logic [7:0] PRE_M = 8'b11100010;
  localparam logic [7:0] PRE_W = 8'b11100100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         din = 1'b0;
  logic         vin = 1'b0;
  logic         in_channel = 1'b0;
  logic [7:0]   frame_counter;
  logic         out_channel;
  logic [19:0]  dout;
  logic         vout;
  logic [3:0]   dauxout;
  logic         vauxout;
  logic [191:0] channeldout;
  logic         channelvout;
  logic         done;
  logic         kill;

  frame_dismantle dut (
    .clk           (clk),
    .rst           (rst),
    .din           (din),
    .vin           (vin),
    .in_channel    (in_channel),
    .frame_counter (frame_counter),
    .out_channel   (out_channel),
    .dout          (dout),
    .vout          (vout),
    .dauxout       (dauxout),
    .vauxout       (vauxout),
    .channeldout   (channeldout),
    .channelvout   (channelvout),
    .done          (done),
    .kill          (kill)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  int n_vaux = 0, n_vout = 0, n_done = 0, n_kill = 0, n_cv = 0, excl_err = 0;
  int vaux_cyc = 0, vout_cyc = 0, done_cyc = 0, cv_cyc = 0;
  logic [3:0]  last_daux = 4'd0;
  logic [19:0] last_dout = 20'd0;
  logic        last_och = 1'b0;
  logic [7:0]  last_fc = 8'd0;

  always @(negedge clk) begin
    if (vauxout) begin
      n_vaux   <= n_vaux + 1;
      last_daux <= dauxout;
      vaux_cyc <= cyc;
    end
    if (vout) begin
      n_vout   <= n_vout + 1;
      last_dout <= dout;
      last_och <= out_channel;
      last_fc  <= frame_counter;
      vout_cyc <= cyc;
    end
    if (done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if (kill) n_kill <= n_kill + 1;
    if (channelvout) begin
      n_cv   <= n_cv + 1;
      cv_cyc <= cyc;
    end
    if ((vout && vauxout) || (done && kill)) excl_err <= excl_err + 1;
  end

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int last_cyc = 0, aux_last = 0, aud_last = 0, p_last = 0;

  task automatic send_bit(input logic b, input bit gap);
    if (gap) begin
      @(negedge clk);
      vin = 1'b0;
      din = ~b;
    end
    @(negedge clk);
    din = b;
    vin = 1'b1;
    last_cyc = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vin = 1'b0;
    end
  endtask

  task automatic send_pre(input logic [7:0] pre, input bit gap);
    for (int i = 7; i >= 0; i--) send_bit(pre[i], gap);
  endtask

  task automatic send_body(input logic [3:0] aux, input logic [19:0] aud, input logic c,
                           input bit bad, input bit gap);
    logic p;
    p = (^aux) ^ (^aud) ^ c ^ bad;
    for (int i = 0; i < 4; i++) send_bit(aux[i], gap);
    aux_last = last_cyc;
    for (int i = 0; i < 20; i++) send_bit(aud[i], gap);
    aud_last = last_cyc;
    send_bit(1'b0, gap);
    send_bit(1'b0, gap);
    send_bit(c, gap);
    send_bit(p, gap);
    p_last = last_cyc;
  endtask

  int snap_vaux, snap_kill, snap_done, snap_vout, snap_cv, a191_p;
  logic [191:0] exp_cs;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_dout", 192'(dout), 192'(0));
    check("rst_daux", 192'(dauxout), 192'(0));
    check("rst_cdout", channeldout, 192'(0));
    check("rst_fc", 192'(frame_counter), 192'(0));
    check("rst_strobes", 192'({out_channel, vout, vauxout, channelvout, done, kill}), 192'(0));
    rst = 1'b0;
    idle(2);

    // Channel A block start, continuous vin
    send_pre(PRE_B, 1'b0);
    send_body(4'hA, 20'h12345, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("a_nvaux", 192'(n_vaux), 192'(1));
    check("a_daux", 192'(last_daux), 192'(4'hA));
    check("a_vaux_lat", 192'(vaux_cyc), 192'(aux_last));
    check("a_nvout", 192'(n_vout), 192'(1));
    check("a_dout", 192'(last_dout), 192'(20'h12345));
    check("a_vout_lat", 192'(vout_cyc), 192'(aud_last));
    check("a_och", 192'(last_och), 192'(0));
    check("a_ndone", 192'(n_done), 192'(1));
    check("a_done_lat", 192'(done_cyc), 192'(p_last));
    check("a_nkill", 192'(n_kill), 192'(0));
    check("a_fc", 192'(frame_counter), 192'(0));

    // Channel B of frame 0
    send_pre(PRE_W, 1'b0);
    send_body(4'h3, 20'hFEDCB, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("b_nvout", 192'(n_vout), 192'(2));
    check("b_dout", 192'(last_dout), 192'(20'hFEDCB));
    check("b_och", 192'(last_och), 192'(1));
    check("b_fc", 192'(last_fc), 192'(0));
    check("b_daux_hold", 192'(dauxout), 192'(4'h3));
    check("b_ndone", 192'(n_done), 192'(2));

    // Frame 1 channel A with vin toggling
    send_pre(PRE_M, 1'b1);
    send_body(4'hA, 20'h12345, 1'b0, 1'b0, 1'b1);
    idle(2);
    check("g_daux", 192'(last_daux), 192'(4'hA));
    check("g_vaux_lat", 192'(vaux_cyc), 192'(aux_last));
    check("g_dout", 192'(last_dout), 192'(20'h12345));
    check("g_vout_lat", 192'(vout_cyc), 192'(aud_last));
    check("g_och", 192'(last_och), 192'(0));
    check("g_fc", 192'(frame_counter), 192'(1));
    check("g_ndone", 192'(n_done), 192'(3));
    check("g_nkill", 192'(n_kill), 192'(0));

    // Asynchronous reset in the middle of the aux field
    send_pre(PRE_W, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    @(negedge clk);
    vin = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mr_dout", 192'(dout), 192'(0));
    check("mr_daux", 192'(dauxout), 192'(0));
    check("mr_fc", 192'(frame_counter), 192'(0));
    check("mr_strobes", 192'({out_channel, vout, vauxout, channelvout, done, kill}), 192'(0));
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    snap_vaux = n_vaux;
    snap_kill = n_kill;
    snap_done = n_done;
    send_pre(PRE_B, 1'b0);
    idle(3);
    check("mr_no_vaux", 192'(n_vaux), 192'(snap_vaux));
    check("mr_no_kill", 192'(n_kill), 192'(snap_kill));
    check("mr_no_done", 192'(n_done), 192'(snap_done));
    send_body(4'h5, 20'h0F0F0, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("mr_daux", 192'(last_daux), 192'(4'h5));
    check("mr_dout2", 192'(last_dout), 192'(20'h0F0F0));
    check("mr_ndone", 192'(n_done), 192'(snap_done + 1));
    check("mr_fc2", 192'(frame_counter), 192'(0));

    // Parity error on channel B
    snap_kill = n_kill;
    snap_done = n_done;
    snap_vout = n_vout;
    send_pre(PRE_W, 1'b0);
    send_body(4'h1, 20'h00001, 1'b0, 1'b1, 1'b0);
    idle(2);
    check("pe_nkill", 192'(n_kill), 192'(snap_kill + 1));
    check("pe_ndone", 192'(n_done), 192'(snap_done));
    check("pe_parsed", 192'(n_vout), 192'(snap_vout + 1));

    // Two W preambles in a row
    send_pre(PRE_W, 1'b0);
    send_body(4'h2, 20'h00002, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("ww_nkill", 192'(n_kill), 192'(snap_kill + 2));
    check("ww_ndone", 192'(n_done), 192'(snap_done + 1));

    // Frames 1..191 without a B: sync was lost, so no block may be released
    for (int i = 1; i < 192; i++) begin
      send_pre(PRE_M, 1'b0);
      send_body(i[3:0], {12'h0, i[7:0]}, 1'b1, 1'b0, 1'b0);
      send_pre(PRE_W, 1'b0);
      send_body(4'hF, 20'hAAAAA, 1'b1, 1'b0, 1'b0);
    end
    idle(3);
    check("nb_ncv", 192'(n_cv), 192'(0));
    check("nb_nkill", 192'(n_kill), 192'(snap_kill + 2));
    check("nb_fc", 192'(frame_counter), 192'(191));
    check("nb_cdout", channeldout, 192'(0));

    // Full block, channel A collected, C=1 on even A frames only
    in_channel = 1'b0;
    snap_kill = n_kill;
    a191_p = 0;
    for (int i = 0; i < 192; i++) begin
      send_pre((i == 0) ? PRE_B : PRE_M, 1'b0);
      send_body(i[3:0], {12'h0, i[7:0]}, ~i[0], 1'b0, 1'b0);
      if (i == 191) a191_p = p_last;
      send_pre(PRE_W, 1'b0);
      send_body(4'hF, 20'h55555, 1'b1, 1'b0, 1'b0);
    end
    idle(3);
    for (int j = 0; j < 192; j++) exp_cs[j] = (j % 2 == 0);
    check("fb_ncv", 192'(n_cv), 192'(1));
    check("fb_cv_lat", 192'(cv_cyc), 192'(a191_p + 1));
    check("fb_cdout", channeldout, exp_cs);
    check("fb_nkill", 192'(n_kill), 192'(snap_kill));
    check("fb_fc", 192'(frame_counter), 192'(191));

    // Next B wraps the frame counter; an M right after it is an A-A repeat
    snap_cv = n_cv;
    send_pre(PRE_B, 1'b0);
    send_body(4'h0, 20'h00000, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("wr_fc", 192'(frame_counter), 192'(0));
    check("wr_nkill", 192'(n_kill), 192'(snap_kill));
    send_pre(PRE_M, 1'b0);
    send_body(4'h0, 20'h00000, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("aa_nkill", 192'(n_kill), 192'(snap_kill + 1));
    check("aa_fc", 192'(frame_counter), 192'(1));
    check("aa_ncv", 192'(n_cv), 192'(snap_cv));
    check("exclusive", 192'(excl_err), 192'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
